// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-memory arbiter.
package dmem_arb_pkg;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_e;

  localparam logic OWN_CPU = 1'b0;
  localparam logic OWN_DBG = 1'b1;

  localparam int ADDR_W_DEF     = 5;
  localparam int DATA_W_DEF     = 32;
  localparam int MEM_LAT_DEF    = 1;
  localparam int STARVE_MAX_DEF = 4;
  localparam int MEM_LAT_MIN    = 1;
  localparam int MEM_LAT_MAX    = 7;
  localparam int LAT_CNT_W      = 3;

  // Width needed to hold 0..smax, never below one bit.
  function automatic int starve_w(input int smax);
    return (smax < 1) ? 1 : $clog2(smax + 1);
  endfunction

endpackage

// File: rtl/dmem_arb_pick.sv
// Combinational winner selection: cpu has priority unless dbg has been starved STARVE_MAX times.
module dmem_arb_pick
  import dmem_arb_pkg::*;
#(
  parameter int STARVE_MAX = STARVE_MAX_DEF,
  parameter int SW         = starve_w(STARVE_MAX)
) (
  input  logic          cpu_req_i,
  input  logic          dbg_req_i,
  input  logic [SW-1:0] starve_cnt_i,
  output logic          grant_o,
  output logic          owner_o
);

  always_comb begin
    grant_o = cpu_req_i | dbg_req_i;
    owner_o = OWN_CPU;
    if (dbg_req_i && (!cpu_req_i || starve_cnt_i == SW'(STARVE_MAX)))
      owner_o = OWN_DBG;
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter in front of the single-port data memory (cpu MEM stage + debug loader).
// Define DMEM_ARB_PERF_EN to build the stall/dbg-grant performance counters.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int DATA_W     = DATA_W_DEF,
  parameter int MEM_LAT    = MEM_LAT_DEF,
  parameter int STARVE_MAX = STARVE_MAX_DEF
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic              cpu_req_i,
  input  logic              cpu_we_i,
  input  logic [ADDR_W-1:0] cpu_addr_i,
  input  logic [DATA_W-1:0] cpu_wdata_i,
  output logic [DATA_W-1:0] cpu_rdata_o,
  output logic              cpu_ack_o,
  output logic              cpu_stall_o,
  input  logic              dbg_req_i,
  input  logic              dbg_we_i,
  input  logic [ADDR_W-1:0] dbg_addr_i,
  input  logic [DATA_W-1:0] dbg_wdata_i,
  output logic [DATA_W-1:0] dbg_rdata_o,
  output logic              dbg_ack_o,
  output logic              mem_en_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [DATA_W-1:0] mem_rdata_i,
  output logic [15:0]       perf_stall_cnt_o,
  output logic [15:0]       perf_dbg_cnt_o
);

  localparam int SW = starve_w(STARVE_MAX);

  if (MEM_LAT < MEM_LAT_MIN || MEM_LAT > MEM_LAT_MAX) begin : g_bad_lat
    $error("dmem_arbiter: MEM_LAT out of range");
  end

  state_e               state_q, state_d;
  logic                 owner_q, we_q;
  logic [ADDR_W-1:0]    addr_q;
  logic [DATA_W-1:0]    wdata_q, cpu_rdata_q, dbg_rdata_q;
  logic [LAT_CNT_W-1:0] lat_q, lat_d;
  logic [SW-1:0]        starve_q, starve_d;
  logic                 grant, pick_owner, take;

  dmem_arb_pick #(.STARVE_MAX(STARVE_MAX), .SW(SW)) u_pick (
    .cpu_req_i   (cpu_req_i),
    .dbg_req_i   (dbg_req_i),
    .starve_cnt_i(starve_q),
    .grant_o     (grant),
    .owner_o     (pick_owner)
  );

  assign take = (state_q == IDLE) & start_i & grant;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      lat_q       <= '0;
      starve_q    <= '0;
      owner_q     <= OWN_CPU;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      cpu_rdata_q <= '0;
      dbg_rdata_q <= '0;
    end else begin
      state_q  <= state_d;
      lat_q    <= lat_d;
      starve_q <= starve_d;
      if (take) begin
        owner_q <= pick_owner;
        we_q    <= (pick_owner == OWN_DBG) ? dbg_we_i : cpu_we_i;
        addr_q  <= (pick_owner == OWN_DBG) ? {dbg_addr_i[ADDR_W-1:2], 2'b00}
                                           : {cpu_addr_i[ADDR_W-1:2], 2'b00};
        wdata_q <= (pick_owner == OWN_DBG) ? dbg_wdata_i : cpu_wdata_i;
      end
      if (state_q == DONE) begin
        if (owner_q == OWN_DBG) dbg_rdata_q <= mem_rdata_i;
        else                    cpu_rdata_q <= mem_rdata_i;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    lat_d   = lat_q;
    case (state_q)
      IDLE:  if (take) state_d = ISSUE;
      ISSUE: begin
        lat_d   = LAT_CNT_W'(MEM_LAT - 1);
        state_d = (MEM_LAT == 1) ? DONE : WAIT;
      end
      WAIT: begin
        lat_d = lat_q - LAT_CNT_W'(1);
        if (lat_q <= LAT_CNT_W'(1)) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Starvation only accumulates while dbg is actually waiting behind cpu.
  always_comb begin
    starve_d = starve_q;
    if (state_q == IDLE) begin
      if (!dbg_req_i)                starve_d = '0;
      else if (take)                 starve_d = (pick_owner == OWN_DBG) ? '0 : starve_q + SW'(1);
    end
  end

  always_comb begin
    mem_en_o    = (state_q == ISSUE);
    mem_we_o    = (state_q == ISSUE) & we_q;
    mem_addr_o  = addr_q;
    mem_wdata_o = wdata_q;
    cpu_ack_o   = (state_q == DONE) & (owner_q == OWN_CPU);
    dbg_ack_o   = (state_q == DONE) & (owner_q == OWN_DBG);
    cpu_rdata_o = cpu_ack_o ? mem_rdata_i : cpu_rdata_q;
    dbg_rdata_o = dbg_ack_o ? mem_rdata_i : dbg_rdata_q;
    cpu_stall_o = cpu_req_i & ~cpu_ack_o;
  end

`ifdef DMEM_ARB_PERF_EN
  logic [15:0] stall_cnt_q, dbg_cnt_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stall_cnt_q <= '0;
      dbg_cnt_q   <= '0;
    end else begin
      if (cpu_stall_o && stall_cnt_q != 16'hFFFF)
        stall_cnt_q <= stall_cnt_q + 16'd1;
      if (take && pick_owner == OWN_DBG && dbg_cnt_q != 16'hFFFF)
        dbg_cnt_q <= dbg_cnt_q + 16'd1;
    end
  end

  assign perf_stall_cnt_o = stall_cnt_q;
  assign perf_dbg_cnt_o   = dbg_cnt_q;
`else
  assign perf_stall_cnt_o = 16'd0;
  assign perf_dbg_cnt_o   = 16'd0;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: one MEM_LAT=1 instance with a word memory, one MEM_LAT=3 instance for reset abort.
module tb_dmem_arbiter;
  localparam int AW = 5;
  localparam int DW = 32;

  logic          clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, start, cpu_req, cpu_we, dbg_req, dbg_we;
  logic [AW-1:0] cpu_addr, dbg_addr, mem_addr;
  logic [DW-1:0] cpu_wdata, dbg_wdata, cpu_rdata, dbg_rdata, mem_wdata, mem_rdata;
  logic          cpu_ack, cpu_stall, dbg_ack, mem_en, mem_we;
  logic [15:0]   perf_stall, perf_dbg;

  logic          rst3, cpu_req3, cpu_ack3, cpu_stall3, dbg_ack3, mem_en3, mem_we3;
  logic [AW-1:0] mem_addr3;
  logic [DW-1:0] cpu_rdata3, dbg_rdata3, mem_wdata3, mem_rdata3;
  logic [15:0]   perf_stall3, perf_dbg3;

  int n_vec = 0;
  int n_err = 0;

  dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(1), .STARVE_MAX(4)) u_dut (
    .clk_i(clk), .rst_i(rst), .start_i(start),
    .cpu_req_i(cpu_req), .cpu_we_i(cpu_we), .cpu_addr_i(cpu_addr), .cpu_wdata_i(cpu_wdata),
    .cpu_rdata_o(cpu_rdata), .cpu_ack_o(cpu_ack), .cpu_stall_o(cpu_stall),
    .dbg_req_i(dbg_req), .dbg_we_i(dbg_we), .dbg_addr_i(dbg_addr), .dbg_wdata_i(dbg_wdata),
    .dbg_rdata_o(dbg_rdata), .dbg_ack_o(dbg_ack),
    .mem_en_o(mem_en), .mem_we_o(mem_we), .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata),
    .mem_rdata_i(mem_rdata), .perf_stall_cnt_o(perf_stall), .perf_dbg_cnt_o(perf_dbg)
  );

  dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(3), .STARVE_MAX(4)) u_dut3 (
    .clk_i(clk), .rst_i(rst3), .start_i(1'b1),
    .cpu_req_i(cpu_req3), .cpu_we_i(1'b0), .cpu_addr_i(5'h0C), .cpu_wdata_i(32'h0),
    .cpu_rdata_o(cpu_rdata3), .cpu_ack_o(cpu_ack3), .cpu_stall_o(cpu_stall3),
    .dbg_req_i(1'b0), .dbg_we_i(1'b0), .dbg_addr_i(5'h0), .dbg_wdata_i(32'h0),
    .dbg_rdata_o(dbg_rdata3), .dbg_ack_o(dbg_ack3),
    .mem_en_o(mem_en3), .mem_we_o(mem_we3), .mem_addr_o(mem_addr3), .mem_wdata_o(mem_wdata3),
    .mem_rdata_i(mem_rdata3), .perf_stall_cnt_o(perf_stall3), .perf_dbg_cnt_o(perf_dbg3)
  );

  // 8-word memory, one cycle read latency.
  logic [DW-1:0] mem [8];
  initial begin
    for (int i = 0; i < 8; i++) mem[i] = '0;
    mem_rdata = '0;
  end
  always @(posedge clk)
    if (mem_en) begin
      if (mem_we) mem[mem_addr[4:2]] <= mem_wdata;
      mem_rdata <= mem[mem_addr[4:2]];
    end

  // Three-cycle memory: returns 0xA000_00xx (xx = address) exactly 3 cycles after the strobe.
  logic [DW-1:0] p3 [3];
  initial for (int i = 0; i < 3; i++) p3[i] = '0;
  always @(posedge clk) begin
    p3[0] <= mem_en3 ? (32'hA000_0000 | 32'(mem_addr3)) : 32'h0;
    p3[1] <= p3[0];
    p3[2] <= p3[1];
  end
  assign mem_rdata3 = p3[2];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // One access on port (0=cpu, 1=dbg); lat counts the request cycle through the ack cycle inclusive.
  task automatic access(input bit port, input bit we, input logic [AW-1:0] addr,
                        input logic [DW-1:0] wd, output logic [DW-1:0] rd, output int lat,
                        output int n_en, output int n_stall, output logic [AW-1:0] en_addr);
    bit done;
    done = 1'b0; lat = 1; n_en = 0; n_stall = 0; en_addr = '0;
    if (port) begin dbg_req = 1'b1; dbg_we = we; dbg_addr = addr; dbg_wdata = wd; end
    else      begin cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wd; end
    #1;
    for (int i = 0; i < 20; i++) begin
      if (mem_en) begin n_en++; en_addr = mem_addr; end
      if (cpu_stall) n_stall++;
      if (port ? dbg_ack : cpu_ack) begin done = 1'b1; break; end
      cyc();
      lat++;
    end
    chk(port ? "dbg_ack_seen" : "cpu_ack_seen", 32'(done), 32'd1);
    rd = port ? dbg_rdata : cpu_rdata;
    if (port) dbg_req = 1'b0; else cpu_req = 1'b0;
    cyc();
  endtask

  logic [DW-1:0] rd;
  logic [AW-1:0] ea;
  int            lat, ne, ns;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout exp finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; rst3 = 1'b1; start = 1'b0; cpu_req3 = 1'b0;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    dbg_req = 1'b0; dbg_we = 1'b0; dbg_addr = '0; dbg_wdata = '0;
    cyc(); cyc();
    chk("rst_en",    32'(mem_en),  32'd0);
    chk("rst_acks",  32'({cpu_ack, dbg_ack}), 32'd0);
    chk("rst_addr",  32'(mem_addr), 32'd0);
    chk("rst_rdata", cpu_rdata, 32'd0);
    chk("rst_perf",  {perf_stall, perf_dbg}, 32'd0);
    rst = 1'b0; rst3 = 1'b0; start = 1'b1;
    cyc();

    // Loader writes 5 at 0x04, cpu reads it back.
    access(1'b1, 1'b1, 5'h04, 32'h0000_0005, rd, lat, ne, ns, ea);
    access(1'b0, 1'b0, 5'h04, 32'h0, rd, lat, ne, ns, ea);
    chk("rd_lat",   32'(lat), 32'd3);
    chk("rd_data",  rd, 32'h0000_0005);
    chk("rd_en",    32'(ne), 32'd1);
    chk("rd_stall", 32'(ns), 32'd2);

    // Unaligned cpu address is word-aligned on the memory side.
    access(1'b1, 1'b1, 5'h08, 32'h1234_5678, rd, lat, ne, ns, ea);
    access(1'b0, 1'b0, 5'h0A, 32'h0, rd, lat, ne, ns, ea);
    chk("align_addr", 32'(ea), 32'h08);
    chk("align_data", rd, 32'h1234_5678);

    // dbg read leaves cpu_rdata holding its last value.
    access(1'b1, 1'b0, 5'h04, 32'h0, rd, lat, ne, ns, ea);
    chk("dbg_rdata", rd, 32'h0000_0005);
    chk("cpu_hold",  cpu_rdata, 32'h1234_5678);

    // start_i low blocks the grant but stall still follows the request.
    start = 1'b0; cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 5'h08;
    for (int i = 0; i < 4; i++) begin
      cyc();
      chk("nostart_en",    32'(mem_en), 32'd0);
      chk("nostart_stall", 32'(cpu_stall), 32'd1);
    end
    start = 1'b1;
    access(1'b0, 1'b0, 5'h08, 32'h0, rd, lat, ne, ns, ea);
    chk("start_lat",  32'(lat), 32'd3);
    chk("start_data", rd, 32'h1234_5678);

    // Both requesting: cpu x4 then dbg, repeating.
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 5'h04;
    dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 5'h08;
    for (int g = 0; g < 10; g++) begin
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 10; i++) begin
        cyc();
        if (cpu_ack || dbg_ack) begin seen = 1'b1; break; end
      end
      chk("arb_ack",   32'(seen), 32'd1);
      chk("arb_owner", 32'({cpu_ack, dbg_ack}), (g % 5 == 4) ? 32'b01 : 32'b10);
    end
    cpu_req = 1'b0; dbg_req = 1'b0;
    cyc(); cyc();

    // Perf: 3 dbg grants, then 8 blocked cycles + 2 access cycles of cpu stall.
    rst = 1'b1; cyc(); rst = 1'b0; cyc();
    for (int i = 0; i < 3; i++)
      access(1'b1, 1'b1, 5'(i * 4), 32'(i), rd, lat, ne, ns, ea);
    start = 1'b0; cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 5'h00;
    repeat (8) cyc();
    start = 1'b1;
    access(1'b0, 1'b0, 5'h00, 32'h0, rd, lat, ne, ns, ea);
`ifdef DMEM_ARB_PERF_EN
    chk("perf_stall", 32'(perf_stall), 32'd10);
    chk("perf_dbg",   32'(perf_dbg),   32'd3);
`else
    chk("perf_stall", 32'(perf_stall), 32'd0);
    chk("perf_dbg",   32'(perf_dbg),   32'd0);
`endif

    // MEM_LAT=3: reset while in WAIT aborts the access with no ack.
    cpu_req3 = 1'b1;
    cyc(); cyc();
    chk("l3_inwait_en", 32'(mem_en3), 32'd0);
    rst3 = 1'b1; #1;
    chk("l3_rst_outs", 32'({mem_en3, mem_we3, cpu_ack3, dbg_ack3}), 32'd0);
    chk("l3_rst_addr", 32'(mem_addr3), 32'd0);
    chk("l3_rst_rdata", cpu_rdata3, 32'd0);
    for (int i = 0; i < 4; i++) begin
      cyc();
      chk("l3_noack", 32'(cpu_ack3), 32'd0);
    end
    rst3 = 1'b0; #1;
    lat = 1;
    for (int i = 0; i < 20; i++) begin
      if (cpu_ack3) break;
      cyc();
      lat++;
    end
    chk("l3_lat",  32'(lat), 32'd5);
    chk("l3_data", cpu_rdata3, 32'hA000_000C);
    cpu_req3 = 1'b0;
    cyc();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
Shares the single-port data memory between two requesters: the pipeline MEM stage (port 0, cpu) and the debug/loader port (port 1, dbg) that the bench uses to preload and inspect data.
- Owns the memory enable/write strobes.
- Sequences each access over a fixed memory latency.
- Raises a stall to the pipeline while a CPU access is pending.
- Sits between the CPU top level and the data memory instance.

Parameters:
ADDR_W, 5, byte-address width (32-byte data memory)
DATA_W, 32, data word width
MEM_LAT, 1, cycles from mem_en_o pulse to valid mem_rdata_i; legal range 1..7
STARVE_MAX, 4, consecutive CPU wins after which a waiting dbg request takes priority

Ports:
clk_i  in  1  clock
rst_i  in  1  asynchronous active-high reset
start_i  in  1  grant enable; low blocks new grants, an in-flight access still completes
cpu_req_i  in  1  CPU access request; held until cpu_ack_o
cpu_we_i  in  1  1=write, 0=read
cpu_addr_i  in  ADDR_W  byte address
cpu_wdata_i  in  DATA_W  write data
cpu_rdata_o  out  DATA_W  read data, valid while cpu_ack_o
cpu_ack_o  out  1  one-cycle completion pulse
cpu_stall_o  out  1  cpu_req_i & ~cpu_ack_o (combinational)
dbg_req_i, dbg_we_i, dbg_addr_i, dbg_wdata_i  in  1/1/ADDR_W/DATA_W  same semantics as cpu_*
dbg_rdata_o  out  DATA_W  read data, valid while dbg_ack_o
dbg_ack_o  out  1  one-cycle completion pulse
mem_en_o  out  1  one-cycle access strobe
mem_we_o  out  1  write strobe, qualifies mem_en_o
mem_addr_o  out  ADDR_W  word-aligned address (bits [1:0] forced to 0)
mem_wdata_o  out  DATA_W  write data
mem_rdata_i  in  DATA_W  memory read data
perf_stall_cnt_o  out  16  CPU stall-cycle count (see Optional Feature)
perf_dbg_cnt_o  out  16  dbg grant count (see Optional Feature)

Behaviour:
- Reset: all outputs 0, FSM in IDLE, starvation counter 0, latched request cleared. Reset mid-access aborts it with no ack issued; the requester must re-request.
- FSM states:
  - IDLE: if start_i and any request present, select the winner, latch owner/we/addr/wdata, go to ISSUE. Otherwise stay.
  - ISSUE: mem_en_o=1 for exactly one cycle, mem_we_o=latched we, address/data from the latch. Load the wait counter with MEM_LAT-1. Go to WAIT, or to DONE when MEM_LAT=1.
  - WAIT: decrement the counter; at 0 go to DONE.
  - DONE: capture mem_rdata_i into the owner's rdata register; pulse the owner's ack for one cycle; return to IDLE.
- Latency: grant cycle + ISSUE + (MEM_LAT-1) WAIT + DONE = MEM_LAT+2 cycles from req sampled in IDLE to ack. Back-to-back throughput is one access per MEM_LAT+2 cycles.
- Request changes after the grant cycle are ignored until ack; operands are taken from the latch.
- The requester deasserts req or presents its next request in the cycle after ack. The arbiter never re-grants during the ack cycle, because the FSM is in DONE.
- Arbitration in IDLE:
  - Only one requester: it wins.
  - Both requesting: cpu wins and the starvation counter increments; once counter==STARVE_MAX, dbg wins and the counter clears.
  - Any dbg grant clears the counter. The counter also clears when dbg_req_i is low in IDLE.
- Write accesses also produce ack. rdata is then the value sampled from mem_rdata_i and is don't-care to the requester.
- rdata registers hold their value after ack until the next completion for that port.
- start_i low in IDLE: stay in IDLE; cpu_stall_o still follows cpu_req_i.
- Non-owner outputs: ack is 0 while the other port is being served.

Optional Feature:
DMEM_ARB_PERF_EN
- Defined: perf_stall_cnt_o increments every cycle cpu_stall_o=1; perf_dbg_cnt_o increments on each dbg grant. Both are 16-bit, saturate at 0xFFFF, and clear on reset.
- Undefined: both ports remain and are tied to 0; no counter flops.

Decomposition:
- Package dmem_arb_pkg holds:
  - the state enum (IDLE, ISSUE, WAIT, DONE);
  - the owner encoding (OWN_CPU=0, OWN_DBG=1);
  - default widths and the MEM_LAT legal-range constants.
- One sub-module, dmem_arb_pick: combinational priority/starvation selector (inputs: cpu_req, dbg_req, starve count; outputs: grant, owner). The FSM and latches stay in the top.

Test Plan:
- Reset mid-WAIT with MEM_LAT=3 and a cpu read in flight -> all outputs 0 immediately, no cpu_ack_o; after release, re-request completes normally.
- CPU read 0x04 with memory word 0x0000_0005 and MEM_LAT=1 -> mem_en_o exactly 1 cycle; cpu_ack_o 3 cycles after req; cpu_rdata_o=5; cpu_stall_o high for 2 cycles.
- dbg write 0x08=0x1234_5678, then cpu read 0x0A -> mem_addr_o=0x08 on the cpu access; cpu_rdata_o=0x1234_5678.
- Both requesting continuously with STARVE_MAX=4 -> grant sequence cpu,cpu,cpu,cpu,dbg repeating; dbg never waits more than 5 grants.
- start_i=0 with cpu_req_i=1 -> no mem_en_o, cpu_stall_o=1; raising start_i yields ack MEM_LAT+2 cycles later.
- With DMEM_ARB_PERF_EN, 10 stalled cycles and 3 dbg grants -> perf_stall_cnt_o=10, perf_dbg_cnt_o=3; without the macro, both read 0.
